territory_tally: RTL and testbench

//  Read side of the 160x120 game-state RAM (32768x3, address {x[7:0],y[6:0]}) that the game loop fills during play.
//  On start it scans every visible cell, counts cells owned by each of the four players and ranks the players by area.
//  Its outputs feed the end-of-game podium: ordered_colours drives the number glyphs, and done gates the podium FSM.
//  It is the only reader of the RAM while the game is not running.

---
 rtl/tw_pkg.sv | 28 ++
 rtl/tally_cas.sv | 18 +
 rtl/territory_tally.sv | 161 ++++++++++++++++
 tb/tb_territory_tally.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/tw_pkg.sv
// Shared constants for the territory tally: player colours, screen geometry,
// counter width and the tally FSM encoding.
package tw_pkg;

  localparam int X_CELLS = 160;
  localparam int Y_CELLS = 120;
  localparam int CNT_W   = 15;

  localparam logic [2:0] P1_C = 3'b001;
  localparam logic [2:0] P2_C = 3'b010;
  localparam logic [2:0] P3_C = 3'b100;
  localparam logic [2:0] P4_C = 3'b110;

  localparam logic [11:0] ORDER_RST = {P1_C, P2_C, P3_C, P4_C};

  typedef enum logic [3:0] {
    S_IDLE,
    S_SCAN,
    S_DRAIN,
    S_SORT0,
    S_SORT1,
    S_SORT2,
    S_SORT3,
    S_SORT4,
    S_DONE
  } tw_state_t;

endpackage

// File: rtl/tally_cas.sv
// One compare-and-swap cell on {count, colour} pairs; the larger count leaves
// on hi, and equal counts pass straight through so earlier players keep rank.
module tally_cas #(
  parameter int CNT_W = 15
) (
  input  logic [CNT_W+2:0] a,
  input  logic [CNT_W+2:0] b,
  output logic [CNT_W+2:0] hi,
  output logic [CNT_W+2:0] lo
);

  logic swap;

  assign swap = b[CNT_W+2:3] > a[CNT_W+2:3];
  assign hi   = swap ? b : a;
  assign lo   = swap ? a : b;

endmodule

// File: rtl/territory_tally.sv
// Scans the visible game-state RAM, counts cells per player and ranks the
// players by area for the end-of-game podium.
module territory_tally
  import tw_pkg::*;
(
  input  logic             CLOCK_50,
  input  logic             resetn,
  input  logic             start,
  output logic [14:0]      ram_address,
  input  logic [2:0]       ram_q,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] p1_count,
  output logic [CNT_W-1:0] p2_count,
  output logic [CNT_W-1:0] p3_count,
  output logic [CNT_W-1:0] p4_count,
  output logic [11:0]      ordered_colours
);

  localparam logic [7:0] X_LAST = 8'(X_CELLS - 1);
  localparam logic [6:0] Y_LAST = 7'(Y_CELLS - 1);

  tw_state_t state, state_nxt;

  logic [7:0]       x_p0;
  logic [6:0]       y_p0;
  logic             scan_end_p0;
  logic             issue_p0;
  logic             vld_p1;
  logic             accept;
  logic             sorting;
  logic [1:0]       idx_a, idx_b;
  logic [CNT_W+2:0] cas_a, cas_b, cas_hi, cas_lo;
  logic [CNT_W+2:0] slot_p2  [4];
  logic [CNT_W+2:0] slot_nxt [4];

  assign accept      = start && (state == S_IDLE || state == S_DONE);
  assign issue_p0    = (state == S_SCAN) && !scan_end_p0;
  assign ram_address = {x_p0, y_p0};

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    sorting   = 1'b0;
    unique case (state)
      S_IDLE:  if (start) state_nxt = S_SCAN;
      S_SCAN:  begin busy = 1'b1; if (scan_end_p0) state_nxt = S_DRAIN; end
      S_DRAIN: begin busy = 1'b1; state_nxt = S_SORT0; end
      S_SORT0: begin busy = 1'b1; sorting = 1'b1; state_nxt = S_SORT1; end
      S_SORT1: begin busy = 1'b1; sorting = 1'b1; state_nxt = S_SORT2; end
      S_SORT2: begin busy = 1'b1; sorting = 1'b1; state_nxt = S_SORT3; end
      S_SORT3: begin busy = 1'b1; sorting = 1'b1; state_nxt = S_SORT4; end
      S_SORT4: begin busy = 1'b1; sorting = 1'b1; state_nxt = S_DONE; end
      S_DONE:  begin done = 1'b1; if (start) state_nxt = S_SCAN; end
      default: state_nxt = S_IDLE;
    endcase
  end

  // p0: address issue, y inner / x outer; the last address is held one extra
  // cycle so the FSM leaves SCAN only after its read has returned
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      x_p0        <= '0;
      y_p0        <= '0;
      scan_end_p0 <= 1'b0;
      vld_p1      <= 1'b0;
    end else begin
      vld_p1 <= issue_p0;
      if (accept) begin
        x_p0        <= '0;
        y_p0        <= '0;
        scan_end_p0 <= 1'b0;
      end else if (issue_p0) begin
        if (x_p0 == X_LAST && y_p0 == Y_LAST) begin
          scan_end_p0 <= 1'b1;
        end else if (y_p0 == Y_LAST) begin
          y_p0 <= '0;
          x_p0 <= x_p0 + 8'd1;
        end else begin
          y_p0 <= y_p0 + 7'd1;
        end
      end
    end
  end

  // p1: ram_q aligned with vld_p1; non-player colours are simply not counted
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      p1_count <= '0;
      p2_count <= '0;
      p3_count <= '0;
      p4_count <= '0;
    end else if (accept) begin
      p1_count <= '0;
      p2_count <= '0;
      p3_count <= '0;
      p4_count <= '0;
    end else if (vld_p1) begin
      case (ram_q)
        P1_C:    p1_count <= p1_count + CNT_W'(1);
        P2_C:    p2_count <= p2_count + CNT_W'(1);
        P3_C:    p3_count <= p3_count + CNT_W'(1);
        P4_C:    p4_count <= p4_count + CNT_W'(1);
        default: ;
      endcase
    end
  end

  // p2: five-step sorting network, one compare-and-swap per clock
  always_comb begin
    idx_a = 2'd0;
    idx_b = 2'd1;
    case (state)
      S_SORT1: begin idx_a = 2'd2; idx_b = 2'd3; end
      S_SORT2: begin idx_a = 2'd0; idx_b = 2'd2; end
      S_SORT3: begin idx_a = 2'd1; idx_b = 2'd3; end
      S_SORT4: begin idx_a = 2'd1; idx_b = 2'd2; end
      default: ;
    endcase
    cas_a    = slot_p2[idx_a];
    cas_b    = slot_p2[idx_b];
    slot_nxt = slot_p2;
    if (sorting) begin
      slot_nxt[idx_a] = cas_hi;
      slot_nxt[idx_b] = cas_lo;
    end
  end

  tally_cas #(.CNT_W(CNT_W)) u_cas (
    .a  (cas_a),
    .b  (cas_b),
    .hi (cas_hi),
    .lo (cas_lo)
  );

  always_ff @(posedge CLOCK_50) begin
    if (state == S_DRAIN) begin
      slot_p2[0] <= {p1_count, P1_C};
      slot_p2[1] <= {p2_count, P2_C};
      slot_p2[2] <= {p3_count, P3_C};
      slot_p2[3] <= {p4_count, P4_C};
    end else begin
      slot_p2 <= slot_nxt;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn)
      ordered_colours <= ORDER_RST;
    else if (state == S_SORT4)
      ordered_colours <= {slot_nxt[0][2:0], slot_nxt[1][2:0],
                          slot_nxt[2][2:0], slot_nxt[3][2:0]};
  end

endmodule

// File: tb/tb_territory_tally.sv
// Bench for territory_tally: RAM model, table of scan scenarios with a
// scoreboard of expected tallies, plus restart and mid-scan reset sequences.
module tb_territory_tally;
  import tw_pkg::*;

  localparam int N_VIS = 19200;
  localparam int LAT   = 19207;

  logic             CLOCK_50 = 1'b0;
  logic             resetn;
  logic             start;
  logic [14:0]      ram_address;
  logic [2:0]       ram_q;
  logic             busy, done;
  logic [CNT_W-1:0] p1_count, p2_count, p3_count, p4_count;
  logic [11:0]      ordered_colours;

  logic [2:0] mem [0:32767];

  typedef struct {
    int          pattern;
    logic [11:0] exp_order;
    logic [11:0] prev_order;
  } vec_t;

  typedef struct {
    logic [3:0][CNT_W-1:0] c;
    logic [11:0]           order;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[2];
  logic [3:0][CNT_W-1:0] cnt;
  int n_checks = 0;
  int n_fail   = 0;

  always #10 CLOCK_50 = ~CLOCK_50;
  always @(posedge CLOCK_50) ram_q <= mem[ram_address];

  territory_tally dut (
    .CLOCK_50        (CLOCK_50),
    .resetn          (resetn),
    .start           (start),
    .ram_address     (ram_address),
    .ram_q           (ram_q),
    .busy            (busy),
    .done            (done),
    .p1_count        (p1_count),
    .p2_count        (p2_count),
    .p3_count        (p3_count),
    .p4_count        (p4_count),
    .ordered_colours (ordered_colours)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic logic [14:0] expaddr(input int k);
    logic [7:0] xx;
    logic [6:0] yy;
    xx = 8'(k / 120);
    yy = 7'(k % 120);
    return {xx, yy};
  endfunction

  // pattern 0: 50 cells of each player; pattern 1: 10/300/5/3000 with
  // 111 on row 119 and 101/011 filler; off-screen rows hold decoy 001
  task automatic fill(input int pat, output logic [3:0][CNT_W-1:0] c);
    int k;
    logic [2:0] v;
    logic [7:0] xx;
    logic [6:0] yy;
    c = '0;
    k = 0;
    for (int x = 0; x < 160; x++) begin
      for (int y = 0; y < 128; y++) begin
        xx = x[7:0];
        yy = y[6:0];
        if (y >= 120)               v = 3'b001;
        else if (pat == 0) begin
          if      (k < 50)  v = 3'b001;
          else if (k < 100) v = 3'b010;
          else if (k < 150) v = 3'b100;
          else if (k < 200) v = 3'b110;
          else              v = 3'b000;
          k++;
        end else if (y == 119)      v = 3'b111;
        else begin
          if      (k < 10)   v = 3'b001;
          else if (k < 310)  v = 3'b010;
          else if (k < 315)  v = 3'b100;
          else if (k < 3315) v = 3'b110;
          else if (k < 3515) v = 3'b101;
          else               v = 3'b011;
          k++;
        end
        mem[{xx, yy}] = v;
        if (y < 120) begin
          case (v)
            3'b001:  c[0] = c[0] + 1'b1;
            3'b010:  c[1] = c[1] + 1'b1;
            3'b100:  c[2] = c[2] + 1'b1;
            3'b110:  c[3] = c[3] + 1'b1;
            default: ;
          endcase
        end
      end
    end
  endtask

  task automatic run_scan(input bit hold, input logic [3:0][CNT_W-1:0] ecnt,
                          input logic [11:0] eord, input logic [11:0] prev_ord,
                          input string tag);
    int   k;
    int   addr_bad;
    int   y_bad;
    bit   got;
    exp_t e;
    addr_bad = 0;
    y_bad    = 0;
    got      = 1'b0;
    e.c      = ecnt;
    e.order  = eord;
    sb_q.push_back(e);
    @(negedge CLOCK_50);
    start = 1'b1;
    @(posedge CLOCK_50);
    #1;
    if (!hold) start = 1'b0;
    check({tag, " accept_busy"}, busy, 1);
    check({tag, " accept_cnt_clr"}, {p1_count, p2_count, p3_count, p4_count}, 0);
    check({tag, " order_kept"}, ordered_colours, prev_ord);
    for (k = 0; k < LAT + 50; k++) begin
      if (k < N_VIS && ram_address !== expaddr(k)) addr_bad++;
      if (ram_address[6:0] >= 7'd120) y_bad++;
      if (done) begin
        got = 1'b1;
        break;
      end
      @(posedge CLOCK_50);
      #1;
    end
    check({tag, " done_latency"}, got ? k : 0, LAT);
    check({tag, " addr_trace_bad"}, addr_bad, 0);
    check({tag, " y_out_of_range"}, y_bad, 0);
    check({tag, " addr_hold_done"}, ram_address, {8'd159, 7'd119});
    check({tag, " busy_in_done"}, busy, 0);
    e = sb_q.pop_front();
    check({tag, " p1_count"}, p1_count, e.c[0]);
    check({tag, " p2_count"}, p2_count, e.c[1]);
    check({tag, " p3_count"}, p3_count, e.c[2]);
    check({tag, " p4_count"}, p4_count, e.c[3]);
    check({tag, " ordered"}, ordered_colours, e.order);
  endtask

  initial begin
    #1_800_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{0, 12'b001_010_100_110, 12'b001_010_100_110};
    vecs[1] = '{1, 12'b110_010_001_100, 12'b001_010_100_110};

    resetn = 1'b0;
    start  = 1'b0;
    repeat (3) @(posedge CLOCK_50);
    #1;
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst addr", ram_address, 0);
    check("rst counts", {p1_count, p2_count, p3_count, p4_count}, 0);
    check("rst ordered", ordered_colours, 12'b001_010_100_110);
    @(negedge CLOCK_50);
    resetn = 1'b1;
    repeat (3) @(posedge CLOCK_50);
    #1;
    check("idle no start busy", busy, 0);

    for (int i = 0; i < 2; i++) begin
      fill(vecs[i].pattern, cnt);
      run_scan(1'b0, cnt, vecs[i].exp_order, vecs[i].prev_order,
               $sformatf("vec%0d", i));
    end

    // start held from DONE: rescan pattern 1, ordering stays until SORT
    run_scan(1'b1, cnt, 12'b110_010_001_100, 12'b110_010_001_100, "hold");

    // start still high: the very next edge accepts again and clears counts
    @(posedge CLOCK_50);
    #1;
    check("b2b busy", busy, 1);
    check("b2b done", done, 0);
    check("b2b cnt_clr", {p1_count, p2_count, p3_count, p4_count}, 0);
    check("b2b addr", ram_address, 0);

    repeat (4999) @(posedge CLOCK_50);
    #5;
    resetn = 1'b0;
    start  = 1'b0;
    #1;
    check("midrst busy", busy, 0);
    check("midrst done", done, 0);
    check("midrst addr", ram_address, 0);
    check("midrst counts", {p1_count, p2_count, p3_count, p4_count}, 0);
    check("midrst ordered", ordered_colours, 12'b001_010_100_110);
    repeat (3) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    resetn = 1'b1;
    @(posedge CLOCK_50);
    #1;
    check("post rst idle done", done, 0);
    check("post rst idle busy", busy, 0);

    @(negedge CLOCK_50);
    start = 1'b1;
    @(posedge CLOCK_50);
    #1;
    start = 1'b0;
    for (int j = 0; j < 5; j++) begin
      check($sformatf("restart addr%0d", j), ram_address, expaddr(j));
      check($sformatf("restart busy%0d", j), busy, 1);
      @(posedge CLOCK_50);
      #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
